ifu_prefetch: RTL and testbench
===============================

IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the address width.
REQ-002 Parameter DEPTH, default 4, SHALL set the prefetch queue depth; it SHALL be a power of two and at least 2.
REQ-003 Parameter RESET_ADDR, default 32'h00000000, SHALL set the fetch PC after reset.
REQ-004 Parameter PC_STEP, default 4, SHALL set the fetch PC increment per accepted word.
REQ-005 Ports SHALL be, one per line, as follows:
- clock_in  in  1  single clock; all logic on the rising edge.
- reset_in  in  1  synchronous, active-low reset.
- halt_in  in  1  stop issuing new memory reads.
- redirect_in  in  1  flush the queue and restart fetch.
- redirect_addr_in  in  XLEN  new fetch PC, sampled when redirect_in=1.
- mem_addr_out  out  XLEN  instruction read address.
- mem_read_out  out  1  read request.
- mem_valid_in  in  1  read data valid; completes the request.
- mem_data_in  in  32  instruction word.
- ir_data_out  out  32  queue-head instruction.
- ir_addr_out  out  XLEN  queue-head PC.
- ir_valid_out  out  1  queue not empty.
- ir_ready_in  in  1  consumer accepts the head.
- fifo_count_out  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-006 The FSM SHALL have three states: IDLE, REQ and DISCARD; mem_read_out SHALL be 1 exactly in REQ and DISCARD.
REQ-007 In REQ and DISCARD, mem_addr_out SHALL hold stable until the cycle in which mem_valid_in=1; at most one read SHALL be outstanding.
REQ-008 IDLE->REQ SHALL occur when halt_in=0, redirect_in=0 and fifo_count_out<DEPTH; mem_addr_out SHALL equal the fetch PC.
REQ-009 In REQ, when mem_valid_in=1:
- {mem_data_in, mem_addr_out} SHALL be pushed to the queue.
- The fetch PC SHALL advance by PC_STEP, modulo 2^XLEN.
REQ-010 From REQ with mem_valid_in=1, the FSM SHALL stay in REQ (back-to-back, one word per cycle) if halt_in=0 and next-cycle occupancy<DEPTH; otherwise it SHALL go to IDLE.
REQ-011 A pop SHALL occur when ir_valid_out=1 and ir_ready_in=1.
REQ-012 A simultaneous push and pop SHALL leave occupancy unchanged, including when the queue is full.
REQ-013 ir_valid_out SHALL equal (fifo_count_out!=0), and ir_data_out/ir_addr_out SHALL present the head entry combinationally from the queue storage.
REQ-014 halt_in SHALL NOT abort an outstanding read; the returning word SHALL still be pushed.
REQ-015 redirect_in=1 SHALL have priority over push, pop and halt; at the next edge:
- The queue SHALL be emptied.
- The fetch PC SHALL be set to redirect_addr_in.
REQ-016 When redirect_in=1 in REQ with mem_valid_in=0, the FSM SHALL enter DISCARD and keep the old address until mem_valid_in=1; that data SHALL be dropped and the FSM SHALL then go to IDLE.
REQ-017 When redirect_in=1 in REQ with mem_valid_in=1, the data SHALL be dropped and the FSM SHALL go to IDLE.
REQ-018 A redirect in DISCARD SHALL update the fetch PC and remain in DISCARD.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-020 When reset_in=0 at a rising edge, the block SHALL set:
- state=IDLE, fetch PC=RESET_ADDR;
- queue pointers and count cleared;
- mem_read_out=0, ir_valid_out=0, fifo_count_out=0.
REQ-021 Reset SHALL override all inputs, including in the middle of an outstanding read; a late mem_valid_in arriving in IDLE SHALL be ignored.
REQ-022 Queue storage need not be reset; ir_data_out SHALL be don't-care while ir_valid_out=0.

Structure
REQ-023 FSM state encodings SHALL reside in a shared package core101_pkg together with the default XLEN.
REQ-024 The queue SHALL be a separate sub-module, ifu_fifo, parametrised by width and DEPTH, with push/pop/flush/count ports; ifu_prefetch SHALL hold only the FSM and the PC.

Verification
REQ-025 Reset release, ir_ready_in=1, memory returns valid the same cycle: mem_read_out=1 from cycle 1; mem_addr_out=0,4,8 on consecutive cycles; ir_addr_out follows one cycle later.
REQ-026 ir_ready_in=0, DEPTH=4: exactly 4 reads complete, fifo_count_out=4, mem_read_out=0; ir_ready_in=1 for one cycle -> count 3 and a new read of address 16 issues.
REQ-027 Full queue, push and pop in the same cycle -> count stays 4 and the head advances by one entry.
REQ-028 Redirect to 32'h100 while a read of 8 is pending with valid 3 cycles later: DISCARD is held at address 8; the data is dropped; the next read is 32'h100; no stale entry appears at ir_*.
REQ-029 halt_in=1 during an outstanding read: the word is pushed; no further mem_read_out while halted; reads resume at the next PC after halt_in=0.
REQ-030 reset_in=0 mid-read with queue count 2: next cycle mem_read_out=0, count 0, and the next read is RESET_ADDR.

Source files
------------

// File: rtl/core101_pkg.sv
// Shared definitions for the core101 fetch path: default address width,
// instruction word width and the prefetch FSM state encoding.
package core101_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_W      = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        DISCARD = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch queue: power-of-two ring buffer with push/pop/flush and an
// occupancy count; the head entry is read combinationally from storage.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic             do_pop_s;
    logic             do_push_s;

    // A full queue still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != FULL) || do_pop_s);
    end

    // Entry storage, deliberately without reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues one outstanding read at a time, tracks the
// fetch PC and fills a small queue that the decode stage drains.
module ifu_prefetch
    import core101_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEFAULT,
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int              PC_STEP    = 4
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     halt_in,
    input  logic                     redirect_in,
    input  logic [XLEN-1:0]          redirect_addr_in,
    output logic [XLEN-1:0]          mem_addr_out,
    output logic                     mem_read_out,
    input  logic                     mem_valid_in,
    input  logic [INSTR_W-1:0]       mem_data_in,
    output logic [INSTR_W-1:0]       ir_data_out,
    output logic [XLEN-1:0]          ir_addr_out,
    output logic                     ir_valid_out,
    input  logic                     ir_ready_in,
    output logic [$clog2(DEPTH):0]   fifo_count_out
);

    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam int              EW       = INSTR_W + XLEN;
    localparam logic [CW-1:0]   FULL     = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);

    fetch_state_e     state_r;
    fetch_state_e     state_nxt_s;
    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  pc_nxt_s;
    logic [XLEN-1:0]  addr_r;
    logic [XLEN-1:0]  addr_nxt_s;
    logic             read_r;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;
    logic [CW-1:0]    count_s;
    logic [CW-1:0]    occ_nxt_s;
    logic [EW-1:0]    head_s;

    assign pop_s     = ir_valid_out && ir_ready_in;
    assign occ_nxt_s = count_s + CNT_ONE - CW'(pop_s);

    // Next-state, PC and queue-control decode; redirect dominates everything.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        addr_nxt_s  = addr_r;
        push_s      = 1'b0;
        flush_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (redirect_in) begin
                    flush_s  = 1'b1;
                    pc_nxt_s = redirect_addr_in;
                end else if (!halt_in && (count_s < FULL)) begin
                    state_nxt_s = REQ;
                    addr_nxt_s  = pc_r;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (redirect_in) begin
                    flush_s     = 1'b1;
                    pc_nxt_s    = redirect_addr_in;
                    state_nxt_s = mem_valid_in ? IDLE : DISCARD;
                end else if (mem_valid_in) begin
                    push_s     = 1'b1;
                    pc_nxt_s   = pc_r + STEP;
                    addr_nxt_s = pc_r + STEP;
                    if (!halt_in && (occ_nxt_s < FULL)) begin
                        state_nxt_s = REQ;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = REQ;
                end
            end
            DISCARD: begin
                // The old address stays on the bus; only the fetch PC follows redirects.
                if (redirect_in) begin
                    flush_s  = 1'b1;
                    pc_nxt_s = redirect_addr_in;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (mem_valid_in) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DISCARD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, PC, bus address and read strobe registers.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state_r <= IDLE;
            pc_r    <= RESET_ADDR;
            addr_r  <= RESET_ADDR;
            read_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            addr_r  <= addr_nxt_s;
            read_r  <= (state_nxt_s != IDLE);
        end
    end

    ifu_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clock_in),
        .rst_n     (reset_in),
        .flush     (flush_s),
        .push      (push_s),
        .push_data ({mem_data_in, addr_r}),
        .pop       (pop_s && !redirect_in),
        .head_data (head_s),
        .count     (count_s)
    );

    assign mem_addr_out   = addr_r;
    assign mem_read_out   = read_r;
    assign ir_data_out    = head_s[EW-1:XLEN];
    assign ir_addr_out    = head_s[XLEN-1:0];
    assign ir_valid_out   = (count_s != '0);
    assign fifo_count_out = count_s;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: a memory model with programmable
// latency, a scoreboard queue of expected fetches, and directed corner cases.
module tb_ifu_prefetch;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        clk;
    logic        reset_in;
    logic        halt_in;
    logic        redirect_in;
    logic [31:0] redirect_addr_in;
    logic [31:0] mem_addr_out;
    logic        mem_read_out;
    logic        mem_valid_in;
    logic [31:0] mem_data_in;
    logic [31:0] ir_data_out;
    logic [31:0] ir_addr_out;
    logic        ir_valid_out;
    logic        ir_ready_in;
    logic [2:0]  fifo_count_out;

    logic        f_rst_n, f_flush, f_push, f_pop;
    logic [7:0]  f_data, f_head;
    logic [2:0]  f_count;

    int errors = 0;
    int total  = 0;

    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
    ent_t        q[$];
    logic [31:0] exp_pc;
    int          latency;
    int          wait_cnt;
    bit          discard;
    bit          spur;

    typedef struct {
        logic        exp_read;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_ir_addr;
    } vec_t;
    vec_t vecs[4];

    ifu_prefetch dut (
        .clock_in         (clk),
        .reset_in         (reset_in),
        .halt_in          (halt_in),
        .redirect_in      (redirect_in),
        .redirect_addr_in (redirect_addr_in),
        .mem_addr_out     (mem_addr_out),
        .mem_read_out     (mem_read_out),
        .mem_valid_in     (mem_valid_in),
        .mem_data_in      (mem_data_in),
        .ir_data_out      (ir_data_out),
        .ir_addr_out      (ir_addr_out),
        .ir_valid_out     (ir_valid_out),
        .ir_ready_in      (ir_ready_in),
        .fifo_count_out   (fifo_count_out)
    );

    ifu_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
        .clk       (clk),
        .rst_n     (f_rst_n),
        .flush     (f_flush),
        .push      (f_push),
        .push_data (f_data),
        .pop       (f_pop),
        .head_data (f_head),
        .count     (f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check occupancy, drive inputs and the memory model, update the scoreboard.
    task automatic tick(input logic rst, input logic halt, input logic redir,
                        input logic [31:0] raddr, input logic rdy);
        logic push_exp;
        @(negedge clk);
        chk("count", 32'(fifo_count_out), 32'(q.size()));
        chk("ir_valid", 32'(ir_valid_out), 32'(q.size() != 0));
        reset_in         = rst;
        halt_in          = halt;
        redirect_in      = redir;
        redirect_addr_in = raddr;
        ir_ready_in      = rdy;
        mem_valid_in     = (mem_read_out && (wait_cnt >= latency)) || spur;
        mem_data_in      = data_of(mem_addr_out);
        if (!rst) begin
            q.delete();
            exp_pc   = RESET_ADDR;
            discard  = 1'b0;
            wait_cnt = 0;
        end else begin
            push_exp = mem_read_out && mem_valid_in && !discard && !redir;
            if (push_exp) chk("rd_addr", mem_addr_out, exp_pc);
            if (!redir && ir_valid_out && rdy && (q.size() != 0)) begin
                chk("ir_addr", ir_addr_out, q[0].addr);
                chk("ir_data", ir_data_out, q[0].data);
                void'(q.pop_front());
            end
            if (push_exp) begin
                q.push_back('{exp_pc, data_of(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            if (redir) begin
                q.delete();
                exp_pc = raddr;
                if (mem_read_out && !mem_valid_in) discard = 1'b1;
            end
            if (mem_read_out && mem_valid_in) begin
                discard  = 1'b0;
                wait_cnt = 0;
            end else if (mem_read_out) begin
                wait_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        latency = 0;
        spur    = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic run(input int n, input logic halt, input logic rdy);
        for (int i = 0; i < n; i++) tick(1'b1, halt, 1'b0, 32'h0, rdy);
    endtask

    task automatic ftick(input logic rst_n, input logic push, input logic [7:0] d, input logic pop);
        @(negedge clk);
        f_rst_n = rst_n; f_flush = 1'b0; f_push = push; f_data = d; f_pop = pop;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
        vecs[2] = '{1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
        vecs[3] = '{1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008};

        reset_in = 1'b0; halt_in = 1'b0; redirect_in = 1'b0; redirect_addr_in = 32'h0;
        mem_valid_in = 1'b0; mem_data_in = 32'h0; ir_ready_in = 1'b0;
        f_rst_n = 1'b0; f_flush = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_data = 8'h00;
        exp_pc = RESET_ADDR; latency = 0; wait_cnt = 0; discard = 1'b0; spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and streaming with zero-latency memory.
        do_reset();
        chk("rst_read", 32'(mem_read_out), 32'd0);
        chk("rst_valid", 32'(ir_valid_out), 32'd0);
        chk("rst_count", 32'(fifo_count_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("stream_read", 32'(mem_read_out), 32'(vecs[i].exp_read));
            chk("stream_addr", mem_addr_out, vecs[i].exp_addr);
            chk("stream_valid", 32'(ir_valid_out), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk("stream_ir_addr", ir_addr_out, vecs[i].exp_ir_addr);
        end

        // Consumer stalled: queue fills to DEPTH, one pop restarts fetch at 16.
        do_reset();
        run(6, 1'b0, 1'b0);
        chk("full_count", 32'(fifo_count_out), 32'd4);
        chk("full_read", 32'(mem_read_out), 32'd0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("pop1_count", 32'(fifo_count_out), 32'd3);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("refill_read", 32'(mem_read_out), 32'd1);
        chk("refill_addr", mem_addr_out, 32'd16);
        run(3, 1'b0, 1'b1);

        // Redirect while the read of 8 is pending.
        do_reset();
        run(3, 1'b0, 1'b1);
        latency = 3;
        tick(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
        chk("disc_read", 32'(mem_read_out), 32'd1);
        chk("disc_addr0", mem_addr_out, 32'd8);
        chk("disc_count", 32'(fifo_count_out), 32'd0);
        run(2, 1'b0, 1'b1);
        chk("disc_addr2", mem_addr_out, 32'd8);
        run(1, 1'b0, 1'b1);
        chk("disc_done_read", 32'(mem_read_out), 32'd0);
        run(1, 1'b0, 1'b1);
        chk("redir_read", 32'(mem_read_out), 32'd1);
        chk("redir_addr", mem_addr_out, 32'h0000_0100);
        latency = 0;
        run(4, 1'b0, 1'b1);

        // Halt during an outstanding read.
        do_reset();
        latency = 2;
        run(1, 1'b0, 1'b1);
        run(3, 1'b1, 1'b1);
        chk("halt_read0", 32'(mem_read_out), 32'd0);
        run(2, 1'b1, 1'b1);
        chk("halt_read1", 32'(mem_read_out), 32'd0);
        run(1, 1'b0, 1'b1);
        chk("resume_read", 32'(mem_read_out), 32'd1);
        chk("resume_addr", mem_addr_out, 32'd4);
        latency = 0;
        run(3, 1'b0, 1'b1);

        // Reset in the middle of a read with two entries queued; late valid ignored.
        do_reset();
        run(3, 1'b0, 1'b0);
        latency = 5;
        run(1, 1'b0, 1'b0);
        chk("mid_count", 32'(fifo_count_out), 32'd2);
        chk("mid_read", 32'(mem_read_out), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("mrst_read", 32'(mem_read_out), 32'd0);
        chk("mrst_count", 32'(fifo_count_out), 32'd0);
        latency = 0;
        spur = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        spur = 1'b0;
        chk("mrst_next_read", 32'(mem_read_out), 32'd1);
        chk("mrst_next_addr", mem_addr_out, RESET_ADDR);
        chk("late_valid_cnt", 32'(fifo_count_out), 32'd0);
        run(3, 1'b0, 1'b1);

        // PC wraps modulo 2^32 after a redirect near the top.
        tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        run(7, 1'b0, 1'b1);

        // Queue sub-module: push and pop together while full.
        ftick(1'b0, 1'b0, 8'h00, 1'b0);
        ftick(1'b1, 1'b1, 8'h11, 1'b0);
        ftick(1'b1, 1'b1, 8'h22, 1'b0);
        ftick(1'b1, 1'b1, 8'h33, 1'b0);
        ftick(1'b1, 1'b1, 8'h44, 1'b0);
        chk("fifo_full", 32'(f_count), 32'd4);
        chk("fifo_head0", 32'(f_head), 32'h11);
        ftick(1'b1, 1'b1, 8'h55, 1'b0);
        chk("fifo_ovf_cnt", 32'(f_count), 32'd4);
        chk("fifo_ovf_head", 32'(f_head), 32'h11);
        ftick(1'b1, 1'b1, 8'h66, 1'b1);
        chk("fifo_pp_cnt", 32'(f_count), 32'd4);
        chk("fifo_pp_head", 32'(f_head), 32'h22);
        ftick(1'b1, 1'b0, 8'h00, 1'b1);
        chk("fifo_pop_head1", 32'(f_head), 32'h33);
        ftick(1'b1, 1'b0, 8'h00, 1'b1);
        chk("fifo_pop_head2", 32'(f_head), 32'h44);
        ftick(1'b1, 1'b0, 8'h00, 1'b1);
        chk("fifo_pop_head3", 32'(f_head), 32'h66);
        chk("fifo_pop_cnt", 32'(f_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
